// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-master memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, WAIT, RESP)
//   GNT_M0/M1   : encoding of the granted master (0 = fetch, 1 = load/store)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin choice.
//   valid[1:0]  in  : request pending per master (bit 1 = m1, bit 0 = m0)
//   last_grant  in  : master granted most recently
//   gnt_valid   out : at least one request pending
//   gnt         out : chosen master (meaningful only with gnt_valid)
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |valid;
    if (valid == 2'b11) begin
      // On a tie the master that did not win last time goes first.
      gnt = ~last_grant;
    end else if (valid[1]) begin
      gnt = GNT_M1;
    end else begin
      gnt = GNT_M0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between master 0 (instruction fetch)
// and master 1 (load/store unit) with round-robin fairness and a response
// watchdog.
//   clk, rst                       : clock, asynchronous active-low reset
//   mN_req_valid/ready             : request handshake per master
//   mN_addr/wen/wdata/wmask        : request fields per master
//   mN_resp_valid/rdata/err        : one-cycle response per master
//   mem_req_valid/ready            : request handshake towards memory
//   mem_addr/wen/wdata/wmask       : registered request fields to memory
//   mem_resp_valid/mem_rdata       : memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int            TW  = $clog2(TIMEOUT + 1);
  localparam int            MW  = DATA_W / 8;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              pick_vld;
  logic              pick_gnt;
  logic [TW-1:0]     timer_inc;
  logic              tmo_hit;

  rr_pick2 u_pick (
    .valid      ({m1_req_valid, m0_req_valid}),
    .last_grant (last_q),
    .gnt_valid  (pick_vld),
    .gnt        (pick_gnt)
  );

  // Saturating increment; tmo_hit flags the cycle in which the count reaches
  // TIMEOUT, so RESP is entered exactly TIMEOUT cycles after leaving IDLE.
  assign timer_inc = (timer_q == TMO) ? timer_q : timer_q + TW'(1);
  assign tmo_hit   = (timer_inc == TMO);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_M0;
      last_q  <= GNT_M1;
      timer_q <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          timer_d = '0;
          addr_d  = (pick_gnt == GNT_M1) ? m1_addr  : m0_addr;
          wen_d   = (pick_gnt == GNT_M1) ? m1_wen   : m0_wen;
          wdata_d = (pick_gnt == GNT_M1) ? m1_wdata : m0_wdata;
          wmask_d = (pick_gnt == GNT_M1) ? m1_wmask : m0_wmask;
          state_d = REQ;
        end
      end
      REQ: begin
        timer_d = timer_inc;
        // A response only counts once memory has taken the request.
        if (mem_req_ready && mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_inc;
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    if ((state_q == IDLE) && pick_vld) begin
      m0_req_ready = (pick_gnt == GNT_M0);
      m1_req_ready = (pick_gnt == GNT_M1);
    end
    mem_req_valid = (state_q == REQ);
    m0_resp_valid = (state_q == RESP) && (gnt_q == GNT_M0);
    m1_resp_valid = (state_q == RESP) && (gnt_q == GNT_M1);
    m0_err        = m0_resp_valid && err_q;
    m1_err        = m1_resp_valid && err_q;
  end

  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed sequences, a round-robin vector table and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] vld;  // {m1, m0} request valid
    logic [1:0] exp;  // {m1, m0} expected req_ready / resp_valid
  } vec_t;

  // Contents returned by the memory model for a given address.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] wm);
    if (m == 0) begin
      m0_req_valid = v; m0_addr = a; m0_wen = w; m0_wdata = wd; m0_wmask = wm;
    end else begin
      m1_req_valid = v; m1_addr = a; m1_wen = w; m1_wdata = wd; m1_wmask = wm;
    end
  endtask

  task automatic idle_inputs();
    drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // One transaction from a single master. rdy_d: REQ cycles before
  // mem_req_ready (-1 = never); rsp_d: cycles from ready to response
  // (-1 = never). Checks every cycle from accept to one cycle after response.
  task automatic txn(input int m, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] wm, input int rdy_d, input int rsp_d,
                     input logic [31:0] md, input string nm);
    int   rdy_k, rsp_k, out_k, end_k;
    logic ok;
    rdy_k = (rdy_d < 0) ? -1 : 1 + rdy_d;
    rsp_k = (rdy_k < 0 || rsp_d < 0) ? -1 : rdy_k + rsp_d;
    ok    = (rsp_k >= 0);
    out_k = ok ? rsp_k + 1 : 1 + TMO;
    end_k = (rdy_k >= 0) ? rdy_k : TMO;
    drive_m(m, 1'b1, a, w, wd, wm);
    drive_m(1 - m, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #3;
    check({nm, " accept"}, 128'({m1_req_ready, m0_req_ready}), 128'((m == 1) ? 2'b10 : 2'b01));
    next_cycle();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    for (int k = 1; k <= out_k + 1; k++) begin
      mem_req_ready  = (k == rdy_k);
      mem_resp_valid = (k == rsp_k);
      mem_rdata      = (k == rsp_k) ? md : $urandom;
      #3;
      check($sformatf("%s ctl k=%0d", nm, k),
            128'({m1_req_ready, m0_req_ready, mem_req_valid, m1_resp_valid, m0_resp_valid}),
            128'({2'b00, (k <= end_k), (k == out_k) && (m == 1), (k == out_k) && (m == 0)}));
      if (k <= end_k)
        check($sformatf("%s fields k=%0d", nm, k),
              128'({mem_addr, mem_wen, mem_wdata, mem_wmask}), 128'({a, w, wd, wm}));
      if (k == out_k) begin
        check({nm, " err"}, 128'((m == 1) ? m1_err : m0_err), 128'(!ok));
        if (!w || !ok)
          check({nm, " rdata"}, 128'((m == 1) ? m1_rdata : m0_rdata), 128'(ok ? md : 32'h0));
      end
      next_cycle();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    vec_t        tbl[11];
    logic [31:0] ra[2], rd[2];
    logic        rw[2], pend[2];
    logic [3:0]  rm[2];
    logic [31:0] acc_a, acc_d, exp_d;
    logic        acc_w, exp_e, noise_ok;
    logic [3:0]  acc_m;
    int          busy, t_acc, rdy_cyc, rsp_cyc, out_cyc, req_end, mlast, g, exp_m, mode;
    logic [1:0]  exp_rdy, exp_rv;

    // Reset defaults
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    #3;
    check("rst ctl", 128'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                           m0_err, m1_err, mem_req_valid, mem_wen}), 128'(0));
    check("rst fields", 128'({mem_addr, mem_wdata, mem_wmask}), 128'(0));
    check("rst rdata", 128'({m0_rdata, m1_rdata}), 128'(0));
    next_cycle();
    rst = 1'b1;

    txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, "first_load");
    txn(1, 32'h0000_0040, 1'b1, 32'h1234_5678, 4'b0011, 0, 0, 32'hAAAA_5555, "zero_wait");
    txn(1, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, -1, 32'h0, "timeout");
    // Late response three cycles after the timeout response
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    #3;
    check("late resp ignored", 128'({m0_resp_valid, m1_resp_valid, mem_req_valid}), 128'(0));
    next_cycle();
    mem_resp_valid = 1'b0;
    #3;
    check("late resp no pulse", 128'({m0_resp_valid, m1_resp_valid, mem_req_valid}), 128'(0));
    next_cycle();
    txn(0, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D, "after_timeout");
    txn(0, 32'h0000_0300, 1'b1, 32'hCAFE_F00D, 4'hF, -1, -1, 32'h0, "stuck");

    // Reset during WAIT; last_grant is m0 here, so a tie after reset going to
    // m0 shows last_grant came back as m1.
    drive_m(0, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'h0);
    #3;
    check("rstmid accept", 128'({m1_req_ready, m0_req_ready}), 128'(2'b01));
    next_cycle();
    m0_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    #3;
    check("rstmid in reset", 128'({m0_req_ready, m1_req_ready, mem_req_valid,
                                   m0_resp_valid, m1_resp_valid}), 128'(0));
    next_cycle();
    next_cycle();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_2222;
    #3;
    check("rstmid stale", 128'({mem_req_valid, m0_resp_valid, m1_resp_valid}), 128'(0));
    next_cycle();
    mem_resp_valid = 1'b0;
    #3;
    check("rstmid no resp", 128'({mem_req_valid, m0_resp_valid, m1_resp_valid}), 128'(0));
    drive_m(0, 1'b1, 32'h0000_4000, 1'b0, 32'h0, 4'h0);
    drive_m(1, 1'b1, 32'h0000_5000, 1'b0, 32'h0, 4'h0);
    #1;
    check("rstmid tie", 128'({m1_req_ready, m0_req_ready}), 128'(2'b01));
    next_cycle();
    idle_inputs();
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_8888;
    next_cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #3;
    check("rstmid resp", 128'({m1_resp_valid, m0_resp_valid, m0_rdata}), 128'({2'b01, 32'h7777_8888}));
    next_cycle();

    // Round-robin table, zero-wait memory, starting from reset (m0 wins first tie)
    tbl[0]  = '{2'b11, 2'b01};
    tbl[1]  = '{2'b11, 2'b10};
    tbl[2]  = '{2'b11, 2'b01};
    tbl[3]  = '{2'b11, 2'b10};
    tbl[4]  = '{2'b00, 2'b00};
    tbl[5]  = '{2'b10, 2'b10};
    tbl[6]  = '{2'b11, 2'b01};
    tbl[7]  = '{2'b01, 2'b01};
    tbl[8]  = '{2'b11, 2'b10};
    tbl[9]  = '{2'b10, 2'b10};
    tbl[10] = '{2'b11, 2'b01};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive_m(0, tbl[i].vld[0], 32'h0000_1000, 1'b0, 32'h0, 4'h0);
      drive_m(1, tbl[i].vld[1], 32'h0000_2000, 1'b0, 32'h0, 4'h0);
      #3;
      check($sformatf("tbl%0d ready", i), 128'({m1_req_ready, m0_req_ready}), 128'(tbl[i].exp));
      next_cycle();
      if (tbl[i].exp != 2'b00) begin
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hC0DE_0000 + 32'(i);
        #3;
        check($sformatf("tbl%0d addr", i), 128'(mem_addr),
              128'(tbl[i].exp[1] ? 32'h0000_2000 : 32'h0000_1000));
        next_cycle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #3;
        check($sformatf("tbl%0d resp", i), 128'({m1_resp_valid, m0_resp_valid}), 128'(tbl[i].exp));
        check($sformatf("tbl%0d rdata", i), 128'(tbl[i].exp[1] ? m1_rdata : m0_rdata),
              128'(32'hC0DE_0000 + 32'(i)));
        next_cycle();
      end
    end
    idle_inputs();

    // Randomized run against a transaction-level model
    do_reset();
    mlast = 1; busy = 0; t_acc = 0; rdy_cyc = -1; rsp_cyc = -1; out_cyc = -1; req_end = -1;
    exp_m = 0; exp_d = 32'h0; exp_e = 1'b0;
    acc_a = 32'h0; acc_d = 32'h0; acc_w = 1'b0; acc_m = 4'h0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; ra[m] = 32'h0; rd[m] = 32'h0; rw[m] = 1'b0; rm[m] = 4'h0;
    end
    for (int c = 0; c < 900; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 2) == 0)) begin
          pend[m] = 1'b1;
          ra[m] = $urandom; rd[m] = $urandom; rw[m] = 1'($urandom); rm[m] = 4'($urandom);
        end
        drive_m(m, pend[m], ra[m], rw[m], rd[m], rm[m]);
      end
      mem_req_ready  = (busy != 0) && (c == rdy_cyc);
      mem_resp_valid = (busy != 0) && (c == rsp_cyc);
      mem_rdata      = mem_resp_valid ? memval(acc_a) : $urandom;
      // Spurious responses only where the arbiter must ignore them
      noise_ok = (busy == 0) || (c == out_cyc) || (rdy_cyc < 0) || (c < rdy_cyc);
      if (!mem_resp_valid && noise_ok && ($urandom_range(0, 3) == 0)) mem_resp_valid = 1'b1;
      #3;
      g = -1;
      if (busy == 0) begin
        if (pend[0] && pend[1]) g = 1 - mlast;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end
      exp_rdy = (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00;
      exp_rv  = ((busy != 0) && (c == out_cyc)) ? ((exp_m == 1) ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("rand ctl c=%0d", c),
            128'({m1_req_ready, m0_req_ready, m1_resp_valid, m0_resp_valid, mem_req_valid}),
            128'({exp_rdy, exp_rv, (busy != 0) && (c > t_acc) && (c <= req_end)}));
      if ((busy != 0) && (c == rdy_cyc))
        check($sformatf("rand fields c=%0d", c),
              128'({mem_addr, mem_wen, mem_wdata, mem_wmask}), 128'({acc_a, acc_w, acc_d, acc_m}));
      if ((busy != 0) && (c == out_cyc)) begin
        check($sformatf("rand err c=%0d", c), 128'((exp_m == 1) ? m1_err : m0_err), 128'(exp_e));
        if (!acc_w || exp_e)
          check($sformatf("rand rdata c=%0d", c), 128'((exp_m == 1) ? m1_rdata : m0_rdata),
                128'(exp_d));
        busy = 0;
      end else if (g >= 0) begin
        busy = 1; t_acc = c; exp_m = g; mlast = g; pend[g] = 1'b0;
        acc_a = ra[g]; acc_w = rw[g]; acc_d = rd[g]; acc_m = rm[g];
        mode    = $urandom_range(0, 7);
        rdy_cyc = (mode == 7) ? -1 : c + 1 + $urandom_range(0, 2);
        rsp_cyc = (mode >= 6) ? -1 : rdy_cyc + $urandom_range(0, 3);
        out_cyc = (mode >= 6) ? c + 1 + TMO : rsp_cyc + 1;
        req_end = (mode == 7) ? c + TMO : rdy_cyc;
        exp_e   = (mode >= 6);
        exp_d   = exp_e ? 32'h0 : memval(acc_a);
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between two requesters: master 0 (instruction fetch) and master 1 (load/store unit). Each master uses a valid/ready request and a one-cycle response pulse. The block sits between the core's fetch/LSU front-ends and the single-port memory model. It serialises accesses with round-robin fairness and a watchdog that turns a missing memory response into an error response.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` byte-mask width.
- `TIMEOUT`, default 255: cycles allowed from leaving IDLE to seeing `mem_resp_valid`; must be ≥ 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m0_req_valid`, `m1_req_valid`  in  1 each  master request pending.
- `m0_req_ready`, `m1_req_ready`  out  1 each  request accepted this cycle.
- `m0_addr`, `m1_addr`  in  `ADDR_W` each  byte address.
- `m0_wen`, `m1_wen`  in  1 each  1 = store, 0 = load.
- `m0_wdata`, `m1_wdata`  in  `DATA_W` each  store data.
- `m0_wmask`, `m1_wmask`  in  `DATA_W/8` each  byte enables.
- `m0_resp_valid`, `m1_resp_valid`  out  1 each  one-cycle response pulse.
- `m0_rdata`, `m1_rdata`  out  `DATA_W` each  load data; valid only with `resp_valid`.
- `m0_err`, `m1_err`  out  1 each  timeout flag; valid only with `resp_valid`.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  request fields, registered.
- `mem_resp_valid`  in  1  memory response.
- `mem_rdata`  in  `DATA_W`  memory read data.

## Operation
- **States:** IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - If exactly one master's `req_valid` is 1, assert that master's `req_ready` combinationally.
  - If both are 1, grant the master that is not `last_grant`.
  - On grant: latch addr/wen/wdata/wmask and `gnt`, set `last_grant <= gnt`, clear the timer, go to REQ.
  - At most one `req_ready` is high in any cycle. Both are 0 outside IDLE.
- **REQ:**
  - Drive `mem_req_valid` = 1 with the latched fields.
  - On `mem_req_ready`, go to WAIT.
  - If `mem_resp_valid` is also 1 in that cycle, capture `mem_rdata` and go directly to RESP with err = 0.
- **WAIT:** On `mem_resp_valid`, capture `mem_rdata` (store responses are captured too; rdata is don't-care to the master) and go to RESP with err = 0.
- **Timer:**
  - Increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT` without a response, go to RESP with err = 1 and rdata = 0.
  - If the memory is still in REQ at that point, drop `mem_req_valid`.
- **RESP:** Pulse `resp_valid` for one cycle to the granted master only, with captured rdata and err. Then go to IDLE.
- **Stale responses:** `mem_resp_valid` in IDLE, RESP, or REQ-without-`mem_req_ready` is ignored. This covers late responses after a timeout.
- **Request stability:** Masters hold valid and fields stable until ready. The arbiter does not check this.
- **Width rules:** The timer width is `$clog2(TIMEOUT+1)` and it saturates at `TIMEOUT`. No address arithmetic is done.

## Timing
- **Reset values:**
  - State = IDLE; `last_grant` = 1, so m0 wins the first tie.
  - Timer = 0; all `*_resp_valid`, `*_err`, and `mem_req_valid` = 0.
  - rdata registers, `mem_addr`, `mem_wdata`, `mem_wmask` = 0; `mem_wen` = 0.
- **Reset mid-operation:** Any transaction in flight is abandoned with no response to the master. A memory response arriving after reset is ignored.
- **Latency:**
  - Accept at cycle T → `mem_req_valid` at T+1.
  - With `mem_req_ready` and `mem_resp_valid` both at T+1, `resp_valid` fires at T+2.
  - In general, `resp_valid` fires 1 cycle after the `mem_resp_valid` that completes the transaction.
- **Throughput:** The next accept is possible at the cycle after RESP, so one transaction takes at least 3 cycles.
- **Timeout:** With no memory activity, `resp_valid` with err = 1 fires at T+1+`TIMEOUT`.

## Structure
- **Package `mem_arbiter_pkg`:** `arb_state_t` enum {IDLE, REQ, WAIT, RESP}, and `GNT_M0` = 1'b0, `GNT_M1` = 1'b1 constants.
- **Sub-module `rr_pick2`:** combinational two-way round-robin choice. Inputs: `valid[1:0]` and `last_grant`. Outputs: `gnt_valid` and `gnt`.
- **Top level:** the FSM, request/response registers, and timer live in `mem_arbiter` itself.

## Test plan
- **Reset defaults:** Hold `rst` low → all outputs 0. Release, then m0 load at 0x80000000 with memory returning 0xDEADBEEF 2 cycles after accept → m0 sees `resp_valid` for 1 cycle, rdata 0xDEADBEEF, err 0. m1 sees nothing.
- **Contention:** Both masters assert valid every cycle for 4 transactions → grants alternate m0, m1, m0, m1. Each response goes only to its requester.
- **Zero-wait memory:** `mem_req_ready` and `mem_resp_valid` both 1 in the first REQ cycle → `resp_valid` at accept+2. m1 store with wmask 4'b0011, wdata 0x12345678 appears unchanged on the `mem_*` fields.
- **Timeout:** TIMEOUT = 8 and memory never responds → `m1_err` = 1, rdata 0, `resp_valid` at accept+9. A `mem_resp_valid` 3 cycles later is ignored, and the next m0 request completes normally.
- **Stuck request:** `mem_req_ready` held 0 → `mem_req_valid` stays high with stable fields until the timeout. It then drops and the master gets err = 1.
- **Reset mid-operation:** Assert `rst` low during WAIT → state returns to IDLE with no response to the master. A `mem_resp_valid` pulse after reset release is ignored, and `last_grant` = 1 so m0 wins the next tie.
